// File: rtl/rv_fetch_pkg.sv
// Shared fetch types and constants for fetch_ctrl and next_pc_sel.
package rv_fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    VALID
  } fetch_state_e;

  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] PC_INC  = 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0013;

endpackage

// File: rtl/next_pc_sel.sv
// Redirect priority (branch > jal > jalr), target masking and misalign check.
// MISALIGN_TRAP_EN: misaligned targets divert to TRAP_VEC and flag o_misalign.
module next_pc_sel
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        i_branch,
  input  logic        i_branch_res,
  input  logic [31:0] i_branch_add,
  input  logic        i_jal,
  input  logic [31:0] i_jal_add,
  input  logic        i_jalr,
  input  logic [31:0] i_jalr_add,
  output logic        o_redir,
  output logic [31:0] o_target,
  output logic        o_misalign
);

  logic        w_taken;
  logic [31:0] w_raw;
  logic [31:0] w_clean;

  assign w_taken = i_branch & i_branch_res;
  assign o_redir = w_taken | i_jal | i_jalr;

  always_comb begin
    w_raw = i_jalr_add & 32'hFFFF_FFFE;
    if (w_taken) begin
      w_raw = i_branch_add;
    end else if (i_jal) begin
      w_raw = i_jal_add;
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign o_misalign = o_redir & w_raw[1];
  assign w_clean    = w_raw;
`else
  assign o_misalign = 1'b0;
  assign w_clean    = w_raw & 32'hFFFF_FFFC;
`endif

  assign o_target = o_misalign ? TRAP_VEC : w_clean;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives one-outstanding imem req/gnt/rvalid port
// and hands instructions to decode over valid/ready. Option: MISALIGN_TRAP_EN.
module fetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC   = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch,
  input  logic               branch_res,
  input  logic [31:0]        branch_add,
  input  logic               jal,
  input  logic [31:0]        jal_add,
  input  logic               jalr,
  input  logic [31:0]        jalr_add,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic [31:0]        pc,
  output logic               misalign_err
);

  fetch_state_e       r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_instr_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_kill;
  logic               r_instr_valid;
  logic               r_misalign_err;

  logic               w_redir;
  logic               w_misalign;
  logic [31:0]        w_target;

  next_pc_sel #(
    .TRAP_VEC(TRAP_VEC)
  ) u_next_pc_sel (
    .i_branch    (branch),
    .i_branch_res(branch_res),
    .i_branch_add(branch_add),
    .i_jal       (jal),
    .i_jal_add   (jal_add),
    .i_jalr      (jalr),
    .i_jalr_add  (jalr_add),
    .o_redir     (w_redir),
    .o_target    (w_target),
    .o_misalign  (w_misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= REQ;
      r_pc           <= RESET_ADDR;
      r_kill         <= 1'b0;
      r_instr_valid  <= 1'b0;
      r_instr        <= '0;
      r_instr_pc     <= '0;
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= w_misalign;
      unique case (r_state)
        REQ: begin
          if (w_redir) r_pc <= w_target;
          // A redirect alongside a grant leaves a stale request in flight.
          if (imem_gnt) begin
            r_kill  <= w_redir;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_kill  <= 1'b0;
            r_state <= REQ;
            if (w_redir) begin
              r_pc <= w_target;
            end else if (!r_kill) begin
              r_instr       <= imem_rdata;
              r_instr_pc    <= r_pc;
              r_pc          <= r_pc + PC_INC;
              r_instr_valid <= 1'b1;
              r_state       <= VALID;
            end
          end else if (w_redir) begin
            r_pc   <= w_target;
            r_kill <= 1'b1;
          end
        end
        VALID: begin
          if (w_redir) r_pc <= w_target;
          if (w_redir || instr_ready) begin
            r_instr_valid <= 1'b0;
            r_state       <= REQ;
          end
        end
        default: r_state <= REQ;
      endcase
    end
  end

  assign imem_req     = (r_state == REQ);
  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign instr_valid  = r_instr_valid;
  assign instr        = r_instr;
  assign instr_pc     = r_instr_pc;
  assign misalign_err = r_misalign_err;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Fetch sequencer that owns the program counter and drives a request/grant/response instruction-memory port. Selects the next PC from sequential increment or execute-stage redirects (taken branch, JAL, JALR) and kills in-flight fetches on redirect. Presents fetched instructions to decode over a valid/ready handshake. Replaces free-running PC stepping so fetch tolerates multi-cycle memory and decode stalls.

Parameters:
RESET_ADDR, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, redirect target on misaligned jump (only with MISALIGN_TRAP_EN)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
branch  input  1  branch instruction in execute (1-cycle pulse)
branch_res  input  1  branch condition true
branch_add  input  32  branch target
jal  input  1  JAL in execute (1-cycle pulse)
jal_add  input  32  JAL target
jalr  input  1  JALR in execute (1-cycle pulse)
jalr_add  input  32  JALR target (raw rs1+imm)
imem_req  output  1  fetch request
imem_addr  output  32  fetch address
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response data valid
imem_rdata  input  32  response instruction
instr_valid  output  1  instruction to decode valid
instr_ready  input  1  decode accepts instruction
instr  output  32  fetched instruction
instr_pc  output  32  address of instr
pc  output  32  current fetch PC register
misalign_err  output  1  1-cycle pulse on misaligned redirect target

Behaviour:
- Reset (async, rst=1): state=REQ, pc=RESET_ADDR, kill=0, instr_valid=0, instr=0, instr_pc=0, misalign_err=0. imem_req=1 from first cycle after reset release.
- imem_req = (state==REQ), imem_addr = pc; both combinational from registers.
- Redirect: redir = (branch&&branch_res) | jal | jalr. Target priority: branch > jal > jalr. JALR target bit0 cleared. Without MISALIGN_TRAP_EN, target[1:0] forced to 2'b00.
- States: REQ, WAIT, VALID.
- REQ: gnt&&!redir -> WAIT. redir&&!gnt -> pc<=target, stay REQ. redir&&gnt -> pc<=target, kill<=1, WAIT.
- WAIT: rvalid&&!kill&&!redir -> instr<=rdata, instr_pc<=pc, pc<=pc+4, instr_valid<=1, VALID. rvalid&&(kill|redir) -> discard, kill<=0, pc<=target if redir, REQ. !rvalid&&redir -> pc<=target, kill<=1, stay WAIT.
- VALID: instr/instr_pc held stable while instr_valid&&!instr_ready. ready -> instr_valid<=0, REQ. redir (with or without ready) -> instr_valid<=0, pc<=target, REQ; a same-cycle ready handshake still counts as accepted.
- Min throughput: 1 instr / 3 cycles (gnt, rvalid the next cycle, ready).
- pc+4 wraps mod 2^32 (32'hFFFF_FFFC -> 0).
- rvalid outside WAIT is ignored. At most one outstanding request.
- Reset mid-fetch: all state cleared immediately. A late rvalid after reset arrives in REQ and is ignored.

Optional Feature:
MISALIGN_TRAP_EN: when defined, a redirect target with target[1]=1 after bit0 clearing pulses misalign_err for 1 cycle and loads pc<=TRAP_VEC instead of the target. When undefined, there is no check, misalign_err is tied 0, and target[1:0] is forced to 00.

Decomposition:
- Shared package rv_fetch_pkg: state enum (REQ/WAIT/VALID), INSTR_W=32, PC_INC=4, NOP=32'h0000_0013.
- One sub-module, next_pc_sel: combinational redirect priority, target masking and misalign check. The FSM and registers stay in fetch_ctrl.

Test Plan:
- Reset with RESET_ADDR=0, gnt=1, rvalid one cycle later, ready=1 -> instr_pc sequence 0,4,8; new instr_valid every 3 cycles.
- Hold instr_ready=0 for 5 cycles in VALID -> instr and instr_pc stable, imem_req=0, pc unchanged.
- jal pulse (jal_add=0x40) in WAIT before rvalid -> response discarded, next imem_addr=0x40, no instr_valid for the stale fetch.
- branch&&branch_res (0x80) and jal (0x40) in the same cycle -> pc=0x80.
- jalr_add=0x23 -> pc=0x20 (no trap build); with MISALIGN_TRAP_EN -> misalign_err pulse, pc=TRAP_VEC.
- pc=0xFFFF_FFFC fetch completes -> pc=0; rst asserted in WAIT -> pc=RESET_ADDR, instr_valid=0 immediately.
